// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writer side of the instruction RAM.
// Operator keys in program words from switches; each Enter press writes one
// word at an auto-incrementing address while the processor is held in reset.
// Optional macro LOADER_ACK_TIMEOUT_EN: abort a write that is not acknowledged
// within ACK_TIMEOUT cycles and raise a sticky Error flag.
`timescale 1ns/1ps

module instr_mem_loader #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 128,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load,
    input  logic              Enter,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              WrAck,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [DATA_W-1:0] WrData,
    output logic              ProcHold,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W:0]   Count,
    output logic              Error,
    output logic [3:0]        State
);

`ifdef LOADER_ACK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int TMO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PRESS = 2'd1,
        WRITE      = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                load_prev_q, enter_prev_q;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                proc_hold_q, proc_hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                error_q, error_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;

    // Prev-registers reset to 1 so a key held through reset gives no edge.
    logic load_edge, enter_edge;
    assign load_edge  = Load  & ~load_prev_q;
    assign enter_edge = Enter & ~enter_prev_q;

    // Next-state and next-output logic for the load session FSM.
    always_comb begin
        state_d     = state_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        proc_hold_d = proc_hold_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        count_d     = count_q;
        error_d     = error_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                if (load_edge) begin
                    state_d     = WAIT_PRESS;
                    wr_addr_d   = '0;
                    count_d     = '0;
                    error_d     = 1'b0;
                    proc_hold_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            WAIT_PRESS: begin
                // Enter wins over a simultaneous Load; that Load edge is lost.
                if (enter_edge) begin
                    wr_data_d = DataIn;
                    wr_en_d   = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = WRITE;
                end else if (load_edge) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            WRITE: begin
                if (WrAck) begin
                    wr_en_d = 1'b0;
                    count_d = count_q + 1'b1;
                    if (wr_addr_q == LAST_ADDR) begin
                        // Memory full: finish without wrapping the address.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                        state_d   = WAIT_PRESS;
                    end
                end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
                    wr_en_d = 1'b0;
                    error_d = 1'b1;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            DONE: begin
                proc_hold_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any session in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            load_prev_q  <= 1'b1;
            enter_prev_q <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            proc_hold_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            count_q      <= '0;
            error_q      <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            load_prev_q  <= Load;
            enter_prev_q <= Enter;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            proc_hold_q  <= proc_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            count_q      <= count_d;
            error_q      <= error_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign WrEn     = wr_en_q;
    assign WrAddr   = wr_addr_q;
    assign WrData   = wr_data_q;
    assign ProcHold = proc_hold_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Count    = count_q;
    assign Error    = TMO_EN ? error_q : 1'b0;
    assign State    = {2'b00, state_q};

endmodule
